csa_cpa_acc: RTL and testbench

Carry-propagate accumulator stage directly downstream of the 4:2 CSA compressor in the MAC datapath. It accepts one redundant result per cycle (sum vector, carry vector, top carry-out) and resolves it to a binary term. It accumulates terms over a run delimited by first/last flags and presents each finished run total on a valid/ready output. Backpressure from the consumer stalls the whole block.

---
 rtl/csa_cpa_acc.sv | 115 +++++++++++
 tb/tb_csa_cpa_acc.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/csa_cpa_acc.sv
`default_nettype none
// ============================================================================
//  Module   : csa_cpa_acc
//  Purpose  : Carry-propagate accumulator behind the 4:2 CSA compressor.
//             Resolves each redundant (sum, carry, carry_out) beat to a binary
//             term, accumulates terms over a first/last delimited run and
//             presents each run total on a valid/ready output. Output
//             backpressure freezes the whole block.
//  Revision : 1.0 - initial release
// ============================================================================
module csa_cpa_acc #(
    parameter int WIDTH     = 24,
    parameter int ACC_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_sum,
    input  logic [WIDTH-1:0]     in_carry,
    input  logic                 in_carry_out,
    input  logic                 in_first,
    input  logic                 in_last,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ACC_WIDTH-1:0] out_acc,
    output logic                 out_overflow
);

    // Stage 1 registers
    logic                 r_s1_valid;
    logic                 r_s1_first;
    logic                 r_s1_last;
    logic [ACC_WIDTH-1:0] r_term;

    // Stage 2 / output registers
    logic [ACC_WIDTH-1:0] r_acc;
    logic                 r_ovf;
    logic [ACC_WIDTH-1:0] r_out_acc;
    logic                 r_out_ovf;
    logic                 r_out_valid;

    // Combinational datapath
    logic                 w_stall;
    logic                 w_accept;
    logic [WIDTH+1:0]     w_term;
    logic [ACC_WIDTH-1:0] w_base;
    logic [ACC_WIDTH:0]   w_sum;
    logic                 w_ovf_next;
    logic                 w_load;

    // A pending result the consumer refuses freezes every register.
    assign w_stall  = r_out_valid && !out_ready;
    assign in_ready = !w_stall;
    assign w_accept = in_valid && !w_stall;

    // Exact resolution of the redundant form: carry bits weigh twice their
    // index, the top carry sits just above the sum vector.
    assign w_term = {2'b00, in_sum}
                  + {1'b0, in_carry, 1'b0}
                  + {1'b0, in_carry_out, {WIDTH{1'b0}}};

    // A first beat restarts from zero, otherwise the running total continues
    // (also across a previous last beat).
    assign w_base     = r_s1_first ? '0 : r_acc;
    assign w_sum      = {1'b0, w_base} + {1'b0, r_term};
    assign w_ovf_next = (r_s1_first ? 1'b0 : r_ovf) | w_sum[ACC_WIDTH];
    assign w_load     = r_s1_valid && r_s1_last;

    // Stage 1: capture the resolved term and run flags of an accepted beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_first <= 1'b0;
            r_s1_last  <= 1'b0;
            r_term     <= '0;
        end else if (!w_stall) begin
            r_s1_valid <= w_accept;
            if (w_accept) begin
                r_s1_first <= in_first;
                r_s1_last  <= in_last;
                r_term     <= ACC_WIDTH'(w_term);
            end
        end
    end

    // Stage 2: accumulate, keep the sticky wrap flag, publish run totals.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc       <= '0;
            r_ovf       <= 1'b0;
            r_out_acc   <= '0;
            r_out_ovf   <= 1'b0;
            r_out_valid <= 1'b0;
        end else if (!w_stall) begin
            if (r_s1_valid) begin
                r_acc <= w_sum[ACC_WIDTH-1:0];
                r_ovf <= w_ovf_next;
            end
            // Not stalled means any held result is being taken this edge,
            // so valid simply follows whether a new total is written.
            r_out_valid <= w_load;
            if (w_load) begin
                r_out_acc <= w_sum[ACC_WIDTH-1:0];
                r_out_ovf <= w_ovf_next;
            end
        end
    end

    assign out_valid    = r_out_valid;
    assign out_acc      = r_out_acc;
    assign out_overflow = r_out_ovf;

endmodule
`default_nettype wire

// File: tb/tb_csa_cpa_acc.sv
`default_nettype none
// ============================================================================
//  Module   : tb_csa_cpa_acc
//  Purpose  : Self-checking bench for csa_cpa_acc: directed scenarios plus
//             randomized runs compared with an arithmetic reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_csa_cpa_acc;

    localparam int WIDTH     = 24;
    localparam int ACC_WIDTH = 32;

    logic                 clk;
    logic                 rst_n;
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     in_sum;
    logic [WIDTH-1:0]     in_carry;
    logic                 in_carry_out;
    logic                 in_first;
    logic                 in_last;
    logic                 out_valid;
    logic                 out_ready;
    logic [ACC_WIDTH-1:0] out_acc;
    logic                 out_overflow;

    csa_cpa_acc #(.WIDTH(WIDTH), .ACC_WIDTH(ACC_WIDTH)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_sum       (in_sum),
        .in_carry     (in_carry),
        .in_carry_out (in_carry_out),
        .in_first     (in_first),
        .in_last      (in_last),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_acc      (out_acc),
        .out_overflow (out_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] acc;
        logic        ovf;
        int          cyc;
    } res_t;

    int   n_vec = 0;
    int   n_err = 0;
    int   cyc   = 0;
    int   last_acc_cyc = 0;
    res_t exp_q[$];
    res_t obs_q[$];
    longint unsigned m_acc = 0;
    logic            m_ovf = 1'b0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        m_acc = 0;
        m_ovf = 1'b0;
        exp_q.delete();
        obs_q.delete();
    endtask

    // Mid-cycle monitor: reference model on accepted beats, scoreboard on
    // output transfers. Inputs only change just after rising edges.
    always @(negedge clk) begin
        res_t e;
        longint unsigned term;
        cyc++;
        if (rst_n) begin
            if (out_valid && out_ready) begin
                obs_q.push_back('{acc: out_acc, ovf: out_overflow, cyc: cyc});
                if (exp_q.size() == 0) begin
                    check("unexpected_output", 64'd1, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("model_acc", 64'(out_acc), 64'(e.acc));
                    check("model_ovf", 64'(out_overflow), 64'(e.ovf));
                end
            end
            if (in_valid && in_ready) begin
                term = longint'(in_sum) + 2 * longint'(in_carry)
                     + (longint'(in_carry_out) << WIDTH);
                if (in_first) begin
                    m_acc = 0;
                    m_ovf = 1'b0;
                end
                m_acc = m_acc + term;
                if (m_acc >= 64'h1_0000_0000) begin
                    m_ovf = 1'b1;
                    m_acc = m_acc - 64'h1_0000_0000;
                end
                if (in_last) exp_q.push_back('{acc: m_acc[31:0], ovf: m_ovf, cyc: cyc});
                last_acc_cyc = cyc;
            end
        end
    end

    // Present one beat and hold it until accepted (called just after a rising edge).
    task automatic send(input logic [23:0] s, input logic [23:0] c, input logic co,
                        input logic f, input logic l);
        int k;
        in_sum = s; in_carry = c; in_carry_out = co; in_first = f; in_last = l;
        in_valid = 1'b1;
        k = 0;
        while (1) begin
            @(negedge clk);
            if (in_ready) break;
            if (k >= 40) begin
                check("send_timeout", 64'd1, 64'd0);
                break;
            end
            @(posedge clk); #1;
            if (k >= 2) out_ready = 1'b1;
            k++;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    // Wait (bounded) for the next output transfer and compare with constants.
    task automatic wait_out(input string tag, input logic [31:0] ea, input logic eo,
                            output int ocyc);
        res_t r;
        int k;
        k = 0;
        ocyc = 0;
        while (obs_q.size() == 0 && k < 30) begin
            @(negedge clk);
            k++;
        end
        if (obs_q.size() == 0) begin
            check({tag, "_timeout"}, 64'd1, 64'd0);
        end else begin
            r = obs_q.pop_front();
            ocyc = r.cyc;
            check({tag, "_acc"}, 64'(r.acc), 64'(ea));
            check({tag, "_ovf"}, 64'(r.ovf), 64'(eo));
        end
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int c1, c2, oc;
        logic [31:0] held;
        rst_n = 1'b0; in_valid = 1'b0; in_sum = '0; in_carry = '0;
        in_carry_out = 1'b0; in_first = 1'b0; in_last = 1'b0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_acc", 64'(out_acc), 64'd0);
        check("rst_out_ovf", 64'(out_overflow), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #1;

        // Single beat: 5 + 2*3 = 11, two cycles accept-to-valid
        send(24'd5, 24'd3, 1'b0, 1'b1, 1'b1);
        wait_out("single", 32'd11, 1'b0, oc);
        check("single_latency", 64'(oc - last_acc_cyc), 64'd2);

        // Top carry weight and the all-ones redundant input
        send(24'd0, 24'd0, 1'b1, 1'b1, 1'b1);
        wait_out("carry_out", 32'h0100_0000, 1'b0, oc);
        send(24'hFF_FFFF, 24'hFF_FFFF, 1'b1, 1'b1, 1'b1);
        wait_out("all_ones", 32'h03FF_FFFD, 1'b0, oc);

        // Back-to-back runs and consecutive output transfers
        for (int b = 0; b < 4; b++) send(24'd100, 24'd0, 1'b0, b == 0, b == 3);
        for (int b = 0; b < 2; b++) send(24'd1, 24'd1, 1'b0, b == 0, b == 1);
        wait_out("run400", 32'd400, 1'b0, c1);
        wait_out("run6", 32'd6, 1'b0, c2);
        check("b2b_spacing", 64'(c2 - c1), 64'd2);

        // Long run that wraps, then a fresh run clears the sticky flag
        for (int b = 0; b < 65; b++) send(24'hFF_FFFF, 24'hFF_FFFF, 1'b1, b == 0, b == 64);
        wait_out("wrap65", 32'h03FF_FF3D, 1'b1, oc);
        send(24'd1, 24'd0, 1'b0, 1'b1, 1'b1);
        wait_out("after_wrap", 32'd1, 1'b0, oc);

        // Backpressure: result pending, more beats in flight
        out_ready = 1'b0;
        send(24'd10, 24'd0, 1'b0, 1'b1, 1'b1);
        send(24'd20, 24'd0, 1'b0, 1'b1, 1'b0);
        in_sum = 24'd30; in_carry = '0; in_carry_out = 1'b0;
        in_first = 1'b0; in_last = 1'b1; in_valid = 1'b1;
        held = out_acc;
        repeat (3) begin
            @(negedge clk);
            check("stall_in_ready", 64'(in_ready), 64'd0);
            check("stall_out_valid", 64'(out_valid), 64'd1);
            check("stall_out_acc", 64'(out_acc), 64'(held));
        end
        check("stall_held_value", 64'(held), 64'd10);
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(negedge clk);
        check("resume_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_out("drain10", 32'd10, 1'b0, oc);
        wait_out("resume50", 32'd50, 1'b0, oc);

        // Reset mid-run after 2 of 4 beats
        send(24'd3, 24'd0, 1'b0, 1'b1, 1'b0);
        send(24'd4, 24'd0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        check("midrun_rst_out_valid", 64'(out_valid), 64'd0);
        check("midrun_rst_out_acc", 64'(out_acc), 64'd0);
        check("midrun_rst_in_ready", 64'(in_ready), 64'd1);
        model_clear();
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Reset while a result is pending
        out_ready = 1'b0;
        send(24'd9, 24'd0, 1'b0, 1'b1, 1'b1);
        @(posedge clk); #1;
        check("pend_out_valid", 64'(out_valid), 64'd1);
        rst_n = 1'b0;
        #1;
        check("pend_rst_out_valid", 64'(out_valid), 64'd0);
        check("pend_rst_out_acc", 64'(out_acc), 64'd0);
        check("pend_rst_out_ovf", 64'(out_overflow), 64'd0);
        check("pend_rst_in_ready", 64'(in_ready), 64'd1);
        model_clear();
        @(posedge clk); #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        send(24'd7, 24'd0, 1'b0, 1'b1, 1'b1);
        wait_out("post_rst", 32'd7, 1'b0, oc);

        // Randomized runs with random gaps and backpressure
        for (int r = 0; r < 40; r++) begin
            int len;
            len = $urandom_range(1, 6);
            for (int b = 0; b < len; b++) begin
                if ($urandom_range(0, 3) == 0) begin
                    out_ready = $urandom_range(0, 1) == 1;
                    idle(1);
                end
                out_ready = $urandom_range(0, 3) != 0;
                send(24'($urandom), 24'($urandom), 1'($urandom),
                     (b == 0) ? ($urandom_range(0, 7) != 0) : 1'b0, b == len - 1);
            end
        end
        out_ready = 1'b1;
        idle(8);
        check("all_results_drained", 64'(exp_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
